// File: rtl/aes_key_sched_seq.sv
// aes_key_sched_seq
//   Sequential AES key expansion for AES-128/192/256, with the key length chosen
//   at runtime. One 32-bit schedule word is produced per clock. All four S-box
//   lanes are shared between RotWord/SubWord (for i mod Nk == 0) and the extra
//   SubWord step that only AES-256 uses (i mod Nk == 4). The finished schedule
//   is held in an internal word store and is read one round key per cycle.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        begin an expansion; taken only while busy == 0
//   key_len      0: AES-128, 1: AES-192, 2: AES-256, 3: rejected with err
//   key          cipher key, left-aligned (word 0 = key[0:31])
//   busy         expansion in progress
//   done         one-cycle pulse on the edge that writes the last word
//   err          one-cycle pulse for a start with key_len == 3
//   keys_valid   the stored schedule is complete and readable
//   rk_rd_en     round-key read strobe
//   rk_addr      round index 0..Nr
//   rk_data      registered round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   rk_valid     rk_data updated by an accepted read (one cycle later)
module aes_key_sched_seq #(
  parameter int MAX_NK = 8,
  parameter int MAX_NR = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [0:32*MAX_NK-1]  key,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  keys_valid,
  input  logic                  rk_rd_en,
  input  logic [3:0]            rk_addr,
  output logic [0:127]          rk_data,
  output logic                  rk_valid
);

  localparam int DEPTH = 4 * (MAX_NR + 1);
  localparam int IW    = $clog2(DEPTH);
  localparam int NKW   = $clog2(MAX_NK + 1);
  localparam int NRW   = $clog2(MAX_NR + 1);
  localparam int PW    = $clog2(MAX_NK);
  localparam int LANES = 4;

  typedef enum logic {IDLE, EXPAND} state_t;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers. The S-box is built arithmetically (inverse, then affine)
  // rather than as a 256-entry table.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] acc;
    x   = a;
    acc = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; a == 0 maps to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a6   = gmul(a3, a3);
    a12  = gmul(a6, a6);
    a15  = gmul(a12, a3);
    a30  = gmul(a15, a15);
    a60  = gmul(a30, a30);
    a120 = gmul(a60, a60);
    a240 = gmul(a120, a120);
    a252 = gmul(a240, a12);
    return gmul(a252, a2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = ginv(a);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t         state;
  logic [NKW-1:0] nk;
  logic [NRW-1:0] nr;
  logic [PW-1:0]  p;       // i mod Nk, kept as a wrapping counter
  logic [IW-1:0]  i;       // index of the word being written
  logic [7:0]     rcon;
  logic [31:0]    w [DEPTH];

  // ---------------------------------------------------------------------------
  // Key-length decode and start qualification
  // ---------------------------------------------------------------------------
  logic [NKW-1:0] nk_sel;
  logic [NRW-1:0] nr_sel;
  logic           start_ok;
  logic           start_bad;

  always_comb begin
    nk_sel = NKW'(4);
    nr_sel = NRW'(10);
    case (key_len)
      2'd1: begin nk_sel = NKW'(6); nr_sel = NRW'(12); end
      2'd2: begin nk_sel = NKW'(8); nr_sel = NRW'(14); end
      default: ;
    endcase
  end

  assign start_ok  = start && !busy && (key_len != 2'd3);
  assign start_bad = start && !busy && (key_len == 2'd3);

  // ---------------------------------------------------------------------------
  // Word generator: w[i] = w[i-Nk] ^ t(w[i-1])
  // ---------------------------------------------------------------------------
  logic [31:0]             prev;
  logic [31:0]             back;
  logic [31:0]             t_word;
  logic [31:0]             new_word;
  logic [LANES-1:0][7:0]   sub_in;
  logic [LANES-1:0][7:0]   sub_out;
  logic                    p_zero;
  logic                    p_sub4;
  logic                    p_wrap;
  logic [IW-1:0]           last_idx;

  assign prev     = w[i - IW'(1)];
  assign back     = w[i - IW'(nk)];
  assign p_zero   = (p == '0);
  assign p_sub4   = (nk == NKW'(8)) && (p == PW'(4));
  assign p_wrap   = (p == PW'(nk - NKW'(1)));
  assign last_idx = IW'({nr, 2'b11});

  // RotWord is applied ahead of the shared S-box only at the start of each Nk group.
  assign sub_in = p_zero ? {prev[23:0], prev[31:24]} : prev;

  for (genvar g = 0; g < LANES; g++) begin : g_sbox
    assign sub_out[g] = sbox(sub_in[g]);
  end

  always_comb begin
    t_word = prev;
    if (p_zero)      t_word = sub_out ^ {rcon, 24'h0};
    else if (p_sub4) t_word = sub_out;
  end

  assign new_word = back ^ t_word;

  // ---------------------------------------------------------------------------
  // Read port word select
  // ---------------------------------------------------------------------------
  logic [IW-1:0] rd_base;
  logic          rd_hit;
  logic [0:127]  rd_word;

  assign rd_base = IW'({rk_addr, 2'b00});
  assign rd_hit  = (rk_addr <= nr);
  assign rd_word = {w[rd_base], w[rd_base + IW'(1)], w[rd_base + IW'(2)], w[rd_base + IW'(3)]};

  // ---------------------------------------------------------------------------
  // Word store. Not reset: keys_valid gates every read of it. All MAX_NK key
  // words are loaded; those beyond Nk are overwritten by the expansion.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (start_ok) begin
      for (int j = 0; j < MAX_NK; j++) w[j] <= key[32*j +: 32];
    end else if (state == EXPAND) begin
      w[i] <= new_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and read port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      keys_valid <= 1'b0;
      rk_valid   <= 1'b0;
      rk_data    <= '0;
      nk         <= NKW'(4);
      nr         <= '0;
      p          <= '0;
      i          <= '0;
      rcon       <= 8'h01;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rk_valid <= 1'b0;

      // The read sees the current (old) schedule even when a start is taken on
      // this same edge; keys_valid only drops afterwards.
      if (rk_rd_en && keys_valid) begin
        rk_valid <= 1'b1;
        rk_data  <= rd_hit ? rd_word : '0;
      end

      case (state)
        IDLE: begin
          if (start_ok) begin
            nk         <= nk_sel;
            nr         <= nr_sel;
            p          <= '0;
            i          <= IW'(nk_sel);
            rcon       <= 8'h01;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
            state      <= EXPAND;
          end else if (start_bad) begin
            err <= 1'b1;
          end
        end
        EXPAND: begin
          i <= i + IW'(1);
          p <= p_wrap ? '0 : p + PW'(1);
          if (p_zero) rcon <= xtime(rcon);
          if (i == last_idx) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            keys_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
